// File: rtl/frame_config_writer.sv
// frame_config_writer
//   Bitstream-side writer for the tile configuration port. Parses a stream of
//   32-bit words (sync / header / data / desync) taken over a valid/ready
//   handshake. Drives the shared FrameData row bus and a one-hot FrameStrobe
//   pulse for the addressed column/frame.
//   Optional build macro: FRAME_WRITER_CHECKSUM_EN adds a running XOR of the
//   data words. It also adds a CHECK state that compares the word following
//   DESYNC against that XOR.

module frame_config_writer #(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumColumns      = 8,
  parameter logic [31:0] SYNC_WORD       = 32'hFAB0_FAB1,
  parameter logic [31:0] DESYNC_WORD     = 32'hFAB0_FADE
) (
  input  logic                                  UserCLK,
  input  logic                                  RESET,
  input  logic [FrameBitsPerRow-1:0]            WordIn,
  input  logic                                  WordValid,
  output logic                                  WordReady,
  output logic [FrameBitsPerRow-1:0]            FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  ConfigBusy,
  output logic [15:0]                           FrameCount,
  output logic                                  Error
);

  localparam int         STROBE_W  = NumColumns * MaxFramesPerCol;
  localparam int         IDX_W     = $clog2(STROBE_W);
  localparam logic [7:0] FRAME_LIM = 8'(MaxFramesPerCol);
  localparam logic [7:0] COL_LIM   = 8'(NumColumns);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_SETUP,
    S_STROBE
`ifdef FRAME_WRITER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t                      r_state;
  logic                        r_ready;
  logic                        r_busy;
  logic [FrameBitsPerRow-1:0]  r_data;
  logic [STROBE_W-1:0]         r_strobe;
  logic [15:0]                 r_count;
  logic                        r_error;
  logic [7:0]                  r_frame;
  logic [7:0]                  r_col;
`ifdef FRAME_WRITER_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0]  r_xor;
`endif

  state_t                      w_next;
  logic                        w_xfer;
  logic                        w_is_sync;
  logic                        w_is_desync;
  logic                        w_hdr_bad;
  logic [IDX_W-1:0]            w_idx;
  logic [STROBE_W-1:0]         w_onehot;

  assign w_xfer      = WordValid && r_ready;
  assign w_is_sync   = (WordIn == SYNC_WORD);
  assign w_is_desync = (WordIn == DESYNC_WORD);
  assign w_hdr_bad   = (WordIn[31:16] != '0) ||
                       (WordIn[7:0]   >= FRAME_LIM) ||
                       (WordIn[15:8]  >= COL_LIM);

  // Ready is only ever high in states that consume a word.
  function automatic logic ready_in(input state_t s);
    case (s)
      S_IDLE, S_HEADER, S_DATA: ready_in = 1'b1;
`ifdef FRAME_WRITER_CHECKSUM_EN
      S_CHECK:                  ready_in = 1'b1;
`endif
      default:                  ready_in = 1'b0;
    endcase
  endfunction

  // Linear strobe index col*MaxFramesPerCol+frame, decoded to a one-hot vector.
  always_comb begin
    w_idx           = IDX_W'(r_col) * IDX_W'(MaxFramesPerCol) + IDX_W'(r_frame);
    w_onehot        = '0;
    w_onehot[w_idx] = 1'b1;
  end

  // Next-state decode of the word parser.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_xfer && w_is_sync) w_next = S_HEADER;
      S_HEADER:
        if (w_xfer) begin
          if (w_is_desync) begin
`ifdef FRAME_WRITER_CHECKSUM_EN
            w_next = S_CHECK;
`else
            w_next = S_IDLE;
`endif
          end else if (w_is_sync) begin
            w_next = S_HEADER;
          end else if (w_hdr_bad) begin
            w_next = S_IDLE;
          end else begin
            w_next = S_DATA;
          end
        end
      S_DATA:
        if (w_xfer) w_next = S_SETUP;
      S_SETUP:
        w_next = S_STROBE;
      S_STROBE:
        w_next = S_HEADER;
`ifdef FRAME_WRITER_CHECKSUM_EN
      S_CHECK:
        if (w_xfer) w_next = S_IDLE;
`endif
      default:
        w_next = S_IDLE;
    endcase
  end

  // State register plus all registered outputs and the datapath.
  // Ready and busy are computed from the next state, so they change on the
  // same edge as the state. Ready therefore first rises one edge after reset
  // is released.
  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_data   <= '0;
      r_strobe <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
      r_frame  <= '0;
      r_col    <= '0;
`ifdef FRAME_WRITER_CHECKSUM_EN
      r_xor    <= '0;
`endif
    end else begin
      r_state  <= w_next;
      r_ready  <= ready_in(w_next);
      r_busy   <= (w_next != S_IDLE);
      r_strobe <= '0;
      case (r_state)
        S_IDLE:
          if (w_xfer && w_is_sync) begin
            r_count <= '0;
            r_error <= 1'b0;
`ifdef FRAME_WRITER_CHECKSUM_EN
            r_xor   <= '0;
`endif
          end
        S_HEADER:
          if (w_xfer && !w_is_desync && !w_is_sync) begin
            if (w_hdr_bad) begin
              r_error <= 1'b1;
            end else begin
              r_frame <= WordIn[7:0];
              r_col   <= WordIn[15:8];
            end
          end
        S_DATA:
          if (w_xfer) begin
            r_data <= WordIn;
`ifdef FRAME_WRITER_CHECKSUM_EN
            r_xor  <= r_xor ^ WordIn;
`endif
          end
        S_SETUP:
          r_strobe <= w_onehot;
        S_STROBE:
          r_count <= r_count + 16'd1;
`ifdef FRAME_WRITER_CHECKSUM_EN
        S_CHECK:
          if (w_xfer && (WordIn != r_xor)) r_error <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign WordReady   = r_ready;
  assign FrameData   = r_data;
  assign FrameStrobe = r_strobe;
  assign ConfigBusy  = r_busy;
  assign FrameCount  = r_count;
  assign Error       = r_error;

endmodule

// File: tb/tb_frame_config_writer.sv
// tb_frame_config_writer
//   Self-checking bench for frame_config_writer: table of single-frame
//   streams, hand-written timing / marker / reset sequences, and randomized
//   multi-frame streams with gaps checked against a word-level parser model.

module tb_frame_config_writer;

  localparam int          MF     = 20;
  localparam int          NC     = 8;
  localparam int          SW     = NC * MF;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FADE;
`ifdef FRAME_WRITER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   WordIn = '0;
  logic          WordValid = 1'b0;
  logic          WordReady;
  logic [31:0]   FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          ConfigBusy;
  logic [15:0]   FrameCount;
  logic          Error;

  always #5 clk = ~clk;

  frame_config_writer #(
    .FrameBitsPerRow(32),
    .MaxFramesPerCol(MF),
    .NumColumns(NC),
    .SYNC_WORD(SYNC),
    .DESYNC_WORD(DESYNC)
  ) dut (
    .UserCLK(clk),
    .RESET(rst),
    .WordIn(WordIn),
    .WordValid(WordValid),
    .WordReady(WordReady),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .ConfigBusy(ConfigBusy),
    .FrameCount(FrameCount),
    .Error(Error)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  typedef struct {
    int          idx;
    logic [31:0] data;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  logic [31:0] prev_fd = '0;

  // Strobe monitor: records every strobe pulse, checks it is one-hot and that
  // FrameData was already stable one cycle earlier.
  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst && FrameStrobe != '0) begin
      e.idx = -1;
      for (int i = 0; i < SW; i++) if (FrameStrobe[i]) e.idx = i;
      e.data = FrameData;
      chk("strobe_onehot", $countones(FrameStrobe), 1);
      chk("data_before_strobe", FrameData, prev_fd);
      obs_q.push_back(e);
    end
    prev_fd = FrameData;
  end

  // Word-level parser model of the bitstream protocol.
  int          m_mode;   // 0 idle, 1 expect header, 2 expect data, 3 expect checksum
  logic [15:0] m_count;
  bit          m_err;
  logic [31:0] m_xor;
  logic [31:0] m_last;
  int          m_frame;
  int          m_col;

  task automatic model_reset();
    m_mode = 0; m_count = '0; m_err = 0; m_xor = '0; m_last = '0;
    m_frame = 0; m_col = 0;
    exp_q.delete();
  endtask

  task automatic model_word(input logic [31:0] w);
    ev_t e;
    case (m_mode)
      0: if (w == SYNC) begin m_mode = 1; m_count = '0; m_err = 0; m_xor = '0; end
      1: begin
        if (w == DESYNC) m_mode = CK ? 3 : 0;
        else if (w != SYNC) begin
          if (w[31:16] != 16'h0 || int'(w[7:0]) >= MF || int'(w[15:8]) >= NC) begin
            m_err = 1; m_mode = 0;
          end else begin
            m_frame = int'(w[7:0]); m_col = int'(w[15:8]); m_mode = 2;
          end
        end
      end
      2: begin
        e.idx = m_col * MF + m_frame; e.data = w;
        exp_q.push_back(e);
        m_count = m_count + 16'd1; m_xor = m_xor ^ w; m_last = w; m_mode = 1;
      end
      default: begin if (w != m_xor) m_err = 1; m_mode = 0; end
    endcase
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    WordIn = w;
    WordValid = 1'b1;
    while (WordReady !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("ready_timeout", {{(SW-1){1'b0}}, WordReady}, 1);
    @(negedge clk);
    WordValid = 1'b0;
    model_word(w);
  endtask

  task automatic do_reset();
    rst = 1'b1; WordValid = 1'b0; WordIn = '0;
    repeat (2) @(negedge clk);
    chk("rst_FrameData", FrameData, 0);
    chk("rst_FrameStrobe", FrameStrobe, 0);
    chk("rst_WordReady", WordReady, 0);
    chk("rst_FrameCount", FrameCount, 0);
    chk("rst_Error", Error, 0);
    chk("rst_ConfigBusy", ConfigBusy, 0);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    obs_q.delete();
  endtask

  task automatic check_round(input string name);
    repeat (4) @(negedge clk);
    chk({name, "_nstrobes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_idx%0d", name, i), obs_q[i].idx, exp_q[i].idx);
      chk($sformatf("%s_data%0d", name, i), obs_q[i].data, exp_q[i].data);
    end
    chk({name, "_count"}, FrameCount, m_count);
    chk({name, "_error"}, Error, m_err);
    chk({name, "_busy"}, ConfigBusy, m_mode != 0);
    chk({name, "_framedata"}, FrameData, m_last);
    obs_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] data;
    bit          err;
    int          idx;
    logic [15:0] cnt;
    logic [31:0] fd;
  } vec_t;

  vec_t vt[7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [SW-1:0] one65;
    logic [31:0]   words[$];
    logic [31:0]   w, dx;
    int            nfr, fr, co;

    vt[0] = '{32'h0000_0305, 32'hDEAD_BEEF, 1'b0, 65,  16'd1, 32'hDEAD_BEEF};
    vt[1] = '{32'h0000_0014, 32'h1111_1111, 1'b1, -1,  16'd0, 32'hDEAD_BEEF};
    vt[2] = '{32'h0001_0000, 32'h2222_2222, 1'b1, -1,  16'd0, 32'hDEAD_BEEF};
    vt[3] = '{32'h0000_0013, 32'h3333_3333, 1'b0, 19,  16'd1, 32'h3333_3333};
    vt[4] = '{32'h0000_0713, 32'h4444_4444, 1'b0, 159, 16'd1, 32'h4444_4444};
    vt[5] = '{32'h0000_0800, 32'h5555_5555, 1'b1, -1,  16'd0, 32'h4444_4444};
    vt[6] = '{32'h0000_0000, DESYNC,        1'b0, 0,   16'd1, DESYNC};

    do_reset();

    // Table: one frame per stream; error rows leave the writer idle so the
    // trailing words are discarded.
    for (int r = 0; r < 7; r++) begin
      obs_q.delete();
      send(SYNC);
      send(vt[r].hdr);
      send(vt[r].data);
      send(DESYNC);
      if (CK) send(vt[r].data);
      repeat (4) @(negedge clk);
      chk($sformatf("row%0d_nstrobes", r), obs_q.size(), (vt[r].idx >= 0) ? 1 : 0);
      if (obs_q.size() > 0 && vt[r].idx >= 0) begin
        chk($sformatf("row%0d_idx", r), obs_q[0].idx, vt[r].idx);
        chk($sformatf("row%0d_data", r), obs_q[0].data, vt[r].data);
      end
      chk($sformatf("row%0d_err", r), Error, vt[r].err);
      chk($sformatf("row%0d_count", r), FrameCount, vt[r].cnt);
      chk($sformatf("row%0d_fd", r), FrameData, vt[r].fd);
      chk($sformatf("row%0d_busy", r), ConfigBusy, 0);
    end

    // Basic frame cycle by cycle with WordValid held high throughout.
    do_reset();
    one65 = '0; one65[65] = 1'b1;
    WordValid = 1'b1; WordIn = SYNC;
    @(negedge clk);
    chk("basic_busy_after_sync", ConfigBusy, 1);
    WordIn = 32'h0000_0305;
    @(negedge clk);
    chk("basic_ready_in_data", WordReady, 1);
    WordIn = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("basic_setup_fd", FrameData, 32'hDEAD_BEEF);
    chk("basic_setup_ready", WordReady, 0);
    chk("basic_setup_strobe", FrameStrobe, 0);
    WordIn = DESYNC;
    @(negedge clk);
    chk("basic_strobe", FrameStrobe, one65);
    chk("basic_strobe_ready", WordReady, 0);
    @(negedge clk);
    chk("basic_after_strobe", FrameStrobe, 0);
    chk("basic_ready_back", WordReady, 1);
    chk("basic_count", FrameCount, 1);
    chk("basic_busy_hdr", ConfigBusy, 1);
    @(negedge clk);
    WordValid = 1'b0;
    chk("basic_busy_after_desync", ConfigBusy, CK);
    if (CK) begin
      WordIn = 32'hDEAD_BEEF; WordValid = 1'b1;
      @(negedge clk);
      WordValid = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("basic_nstrobes", obs_q.size(), 1);
    chk("basic_error", Error, 0);
    model_reset(); m_last = 32'hDEAD_BEEF; m_count = 16'd1;
    obs_q.delete();

    // Marker handling: junk in IDLE, re-sync in HEADER, SYNC value as data.
    send(32'h1234_5678); send(32'h1234_5678);
    repeat (2) @(negedge clk);
    chk("junk_idle_busy", ConfigBusy, 0);
    send(SYNC); send(SYNC);
    chk("resync_busy", ConfigBusy, 1);
    send(32'h0000_0102);
    send(SYNC);
    send(DESYNC);
    if (CK) send(SYNC);
    repeat (4) @(negedge clk);
    chk("marker_nstrobes", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      chk("marker_idx", obs_q[0].idx, 22);
      chk("marker_data", obs_q[0].data, SYNC);
    end
    chk("marker_count", FrameCount, 1);
    chk("marker_busy", ConfigBusy, 0);

    // Reset asserted while a strobe is high.
    obs_q.delete();
    send(SYNC); send(32'h0000_0102); send(32'hAAAA_5555);
    send(32'h0000_0203); send(32'h5555_AAAA);
    @(negedge clk);
    chk("pre_reset_strobe", |FrameStrobe, 1);
    chk("pre_reset_count", FrameCount, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_strobe", FrameStrobe, 0);
    chk("async_rst_count", FrameCount, 0);
    chk("async_rst_ready", WordReady, 0);
    chk("async_rst_busy", ConfigBusy, 0);
    chk("async_rst_fd", FrameData, 0);
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete(); model_reset();
    repeat (10) @(negedge clk);
    chk("post_reset_nstrobes", obs_q.size(), 0);
    chk("post_reset_ready", WordReady, 1);

    // Randomized streams with gaps, checked against the parser model.
    for (int rnd = 0; rnd < 4; rnd++) begin
      words.delete();
      dx = '0;
      words.push_back({16'h1234, 16'($urandom)});
      words.push_back(SYNC);
      nfr = (rnd == 0) ? 4 : $urandom_range(4, 7);
      for (int k = 0; k < nfr; k++) begin
        co = $urandom_range(0, NC - 1);
        fr = (rnd == 0) ? ($urandom_range(0, 1) ? MF - 1 : 0) : $urandom_range(0, MF - 1);
        w = {16'h0, 8'(co), 8'(fr)};
        if (rnd != 0 && $urandom_range(0, 9) == 0) w[7:0] = 8'($urandom_range(MF, 255));
        words.push_back(w);
        w = ($urandom_range(0, 7) == 0) ? DESYNC : 32'($urandom);
        dx = dx ^ w;
        words.push_back(w);
      end
      words.push_back(DESYNC);
      if (CK) words.push_back(dx ^ 32'($urandom_range(0, 1)));
      foreach (words[i]) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(words[i]);
      end
      check_round($sformatf("rand%0d", rnd));
    end

`ifdef FRAME_WRITER_CHECKSUM_EN
    send(SYNC); send(32'h0000_0000); send(32'hF0F0_0000);
    send(32'h0000_0001); send(32'h0F0F_0001); send(DESYNC); send(32'hFFFF_0001);
    repeat (4) @(negedge clk);
    chk("cksum_good_err", Error, 0);
    chk("cksum_good_busy", ConfigBusy, 0);
    send(SYNC); send(32'h0000_0000); send(32'hF0F0_0000);
    send(32'h0000_0001); send(32'h0F0F_0001); send(DESYNC); send(32'hFFFF_0000);
    repeat (4) @(negedge clk);
    chk("cksum_bad_err", Error, 1);
    chk("cksum_bad_busy", ConfigBusy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_config_writer.md
Name: frame_config_writer

Overview:
- Bitstream-side writer for the tile configuration port.
- Accepts a 32-bit configuration word stream over a valid/ready handshake and parses sync, header, data and desync words.
- Drives the fabric FrameData row bus and one-hot per-column FrameStrobe pulses, which the tile ConfigMem latches capture.
- Sits at the fabric top, between the bitstream source (UART/SPI/Wishbone loader) and the column strobe/data buses.

Parameters:
- FrameBitsPerRow, 32: FrameData width and input word width.
- MaxFramesPerCol, 20: strobes per column.
- NumColumns, 8: fabric columns driven.
- SYNC_WORD, 32'hFAB0_FAB1: start-of-bitstream marker.
- DESYNC_WORD, 32'hFAB0_FADE: end-of-bitstream marker.

Ports:
- UserCLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- WordIn  in  FrameBitsPerRow  configuration word.
- WordValid  in  1  WordIn valid.
- WordReady  out  1  writer accepts WordIn this cycle.
- FrameData  out  FrameBitsPerRow  row data bus to all tiles.
- FrameStrobe  out  NumColumns*MaxFramesPerCol  flattened strobes; bit c*MaxFramesPerCol+f is column c, frame f.
- ConfigBusy  out  1  high when not in IDLE.
- FrameCount  out  16  frames written since last sync.
- Error  out  1  sticky protocol error.

Behaviour:
- Transfer rule: a word transfers on a rising edge with WordValid&&WordReady. WordIn is ignored otherwise. The source holds WordIn while WordValid is high and WordReady is low.
- RESET (async): state=IDLE, FrameData=0, FrameStrobe=0, WordReady=0 while RESET is high, FrameCount=0, Error=0, internal regs=0.
  - Reset mid-frame aborts with no strobe issued.
- WordReady=1 in IDLE, HEADER and DATA; 0 in SETUP and STROBE.
- IDLE:
  - Transfer of SYNC_WORD -> HEADER, FrameCount:=0, Error:=0.
  - Any other word is discarded.
- HEADER, decoding the transferred word:
  - == DESYNC_WORD -> IDLE.
  - == SYNC_WORD -> stay HEADER (re-sync, ignored).
  - bits[31:16]!=0, or frame=bits[7:0]>=MaxFramesPerCol, or col=bits[15:8]>=NumColumns -> Error:=1, IDLE.
  - Otherwise latch frame/col -> DATA.
- DATA: transfer of any word (no marker decode) -> FrameData:=word on the same edge -> SETUP.
- SETUP: one cycle, FrameData stable, all strobes 0 -> STROBE.
- STROBE: one cycle.
  - Exactly FrameStrobe[col*MaxFramesPerCol+frame]=1, all other bits 0.
  - On exit: FrameCount+=1 (wraps 16'hFFFF->0) -> HEADER.
- Latency: data word accepted at edge t -> FrameData valid after t -> strobe high during cycle t+2 -> WordReady=1 again at t+3.
- FrameData holds its last value until the next DATA transfer. It is never cleared by DESYNC.
- FrameStrobe is registered, glitch-free and at most one-hot.
- ConfigBusy = (state!=IDLE), registered with state.
- Error is cleared only by RESET or a new SYNC_WORD in IDLE.

Optional Feature:
- Macro FRAME_WRITER_CHECKSUM_EN.
- Defined:
  - A running XOR of all DATA-state words accepted since sync is kept; it is reset to 0 on SYNC_WORD.
  - DESYNC_WORD in HEADER -> CHECK state (WordReady=1).
  - The next transferred word is compared with the XOR. Mismatch -> Error:=1. Either way -> IDLE.
  - ConfigBusy stays high in CHECK.
- Undefined: no CHECK state or XOR register; DESYNC -> IDLE directly.

Test Plan:
- Reset mid-stream: assert RESET during STROBE -> FrameStrobe=0 same cycle (async), FrameCount=0, state IDLE, no further strobes.
- Basic frame: SYNC, header 32'h0000_0305, data 32'hDEAD_BEEF, DESYNC with WordValid held high.
  - FrameData=32'hDEAD_BEEF one cycle before strobe.
  - Only FrameStrobe[3*20+5]=FrameStrobe[65] pulses, for 1 cycle.
  - WordReady low for 2 cycles.
  - FrameCount=1; ConfigBusy falls after DESYNC.
- Backpressure and gaps:
  - Drop WordValid randomly across 4 frames (cols 0..7, frames 0 and 19) -> 4 correct one-hot strobes, FrameCount=4.
  - No word lost or duplicated while WordReady=0.
- Errors: header 32'h0000_0014 (frame 20) -> Error=1, IDLE, no strobe.
  - Header 32'h0001_0000 -> Error=1.
  - Next SYNC clears Error.
- Marker handling:
  - Junk words 32'h1234_5678 in IDLE -> ignored.
  - SYNC in HEADER -> stays HEADER.
  - Data word equal to DESYNC_WORD -> written as data, strobe issued.
- With FRAME_WRITER_CHECKSUM_EN:
  - Data words 32'hF0F0_0000 and 32'h0F0F_0001, then DESYNC, then 32'hFFFF_0001 -> Error=0.
  - The same sequence ending with 32'hFFFF_0000 -> Error=1.
